pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 68 ++++++
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Purpose : Bundles the hazard controller's pipeline-facing signals into one
//           interface. Signal names keep the controller's i_/o_ direction
//           prefixes as seen from the controller.
// Modports:
//   master - the pipeline datapath: drives the ID/EX/MEM hazard inputs and
//            receives the stall/flush controls and status.
//   slave  - the hazard controller: consumes the hazard inputs and drives
//            the controls and status.
// Signals :
//   ID  : i_id_valid, i_id_rs1_addr[4:0], i_id_rs2_addr[4:0],
//         i_id_rs1_used, i_id_rs2_used
//   EX  : i_ex_valid, i_ex_mem_read, i_ex_rd_addr[4:0], i_ex_redirect,
//         i_ex_halt
//   MEM : i_dmem_req, i_dmem_ready
//   Ctl : o_pc_en, o_if_id_stall, o_if_id_flush, o_id_ex_stall_thru,
//         o_id_ex_stall_kill, o_id_ex_flush, o_ex_mem_stall
//   Sts : o_halted, o_stall_cnt[CNT_W-1:0]
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // ID stage
    logic             i_id_valid;
    logic [4:0]       i_id_rs1_addr;
    logic [4:0]       i_id_rs2_addr;
    logic             i_id_rs1_used;
    logic             i_id_rs2_used;
    // EX stage
    logic             i_ex_valid;
    logic             i_ex_mem_read;
    logic [4:0]       i_ex_rd_addr;
    logic             i_ex_redirect;
    logic             i_ex_halt;
    // MEM stage handshake
    logic             i_dmem_req;
    logic             i_dmem_ready;
    // Pipeline controls
    logic             o_pc_en;
    logic             o_if_id_stall;
    logic             o_if_id_flush;
    logic             o_id_ex_stall_thru;
    logic             o_id_ex_stall_kill;
    logic             o_id_ex_flush;
    logic             o_ex_mem_stall;
    // Status
    logic             o_halted;
    logic [CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
        output i_ex_valid, i_ex_mem_read, i_ex_rd_addr, i_ex_redirect, i_ex_halt,
        output i_dmem_req, i_dmem_ready,
        input  o_pc_en, o_if_id_stall, o_if_id_flush, o_id_ex_stall_thru,
        input  o_id_ex_stall_kill, o_id_ex_flush, o_ex_mem_stall,
        input  o_halted, o_stall_cnt
    );

    modport slave (
        input  i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
        input  i_ex_valid, i_ex_mem_read, i_ex_rd_addr, i_ex_redirect, i_ex_halt,
        input  i_dmem_req, i_dmem_ready,
        output o_pc_en, o_if_id_stall, o_if_id_flush, o_id_ex_stall_thru,
        output o_id_ex_stall_kill, o_id_ex_flush, o_ex_mem_stall,
        output o_halted, o_stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Purpose : Hazard/stall/flush controller for a 5-stage in-order pipeline.
//           Resolves, in priority order, data-memory wait, EX redirect,
//           halt, and load-use hazards, and drains the pipeline after a halt.
// Parameters:
//   DRAIN_CYCLES - cycles a halt in EX needs to retire through MEM/WB
//   CNT_W        - width of the saturating stall-cycle counter
// Ports:
//   i_clk - clock
//   i_rst - synchronous, active-high reset
//   hz    - pipe_hazard_ctrl_if.slave: hazard inputs in, pipeline
//           controls and status (o_halted, o_stall_cnt) out
// Control outputs are combinational from state and inputs; o_halted and
// o_stall_cnt are registered.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Wide enough to hold DRAIN_CYCLES itself.
    localparam int DC_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    logic [1:0]       state_q,     state_d;
    logic [DC_W-1:0]  drain_q,     drain_d;
    logic             halted_q,    halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_wait;
    logic redirect;
    logic halt_ex;
    logic load_use;

    logic pc_en;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall_thru;
    logic id_ex_stall_kill;
    logic id_ex_flush;
    logic ex_mem_stall;

    assign mem_wait = hz.i_dmem_req & ~hz.i_dmem_ready;
    assign redirect = hz.i_ex_valid & hz.i_ex_redirect;
    assign halt_ex  = hz.i_ex_valid & hz.i_ex_halt;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = hz.i_ex_valid & hz.i_ex_mem_read & (hz.i_ex_rd_addr != 5'd0) &
                      hz.i_id_valid &
                      ((hz.i_id_rs1_used & (hz.i_id_rs1_addr == hz.i_ex_rd_addr)) |
                       (hz.i_id_rs2_used & (hz.i_id_rs2_addr == hz.i_ex_rd_addr)));

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned; a missing default would infer a latch.
        state_d          = state_q;
        drain_d          = drain_q;
        halted_d         = halted_q;
        stall_cnt_d      = stall_cnt_q;
        pc_en            = 1'b0;
        if_id_stall      = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_stall_thru = 1'b0;
        id_ex_stall_kill = 1'b0;
        id_ex_flush      = 1'b0;
        ex_mem_stall     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    // Freeze everything up to MEM; the EX instruction (and any
                    // redirect/halt it carries) takes effect once MEM completes.
                    if_id_stall      = 1'b1;
                    id_ex_stall_thru = 1'b1;
                    ex_mem_stall     = 1'b1;
                end else if (redirect) begin
                    pc_en       = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (halt_ex) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_d     = DC_W'(DRAIN_CYCLES);
                end else if (load_use) begin
                    // The bubble moves the load out of EX, so the hazard
                    // clears by itself after one cycle.
                    if_id_stall      = 1'b1;
                    id_ex_stall_kill = 1'b1;
                end else begin
                    pc_en = 1'b1;
                end

                if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end

            ST_DRAIN: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_stall = mem_wait;
                if (!mem_wait) begin
                    // Counter of 1 (or 0 for a zero-length drain) is the last
                    // drain cycle; HALTED and o_halted begin together.
                    if (drain_q <= DC_W'(1)) begin
                        drain_d  = '0;
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end

            ST_HALTED: begin
                if_id_stall = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (i_rst) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.o_pc_en            = pc_en;
    assign hz.o_if_id_stall      = if_id_stall;
    assign hz.o_if_id_flush      = if_id_flush;
    assign hz.o_id_ex_stall_thru = id_ex_stall_thru;
    assign hz.o_id_ex_stall_kill = id_ex_stall_kill;
    assign hz.o_id_ex_flush      = id_ex_flush;
    assign hz.o_ex_mem_stall     = ex_mem_stall;
    assign hz.o_halted           = halted_q;
    assign hz.o_stall_cnt        = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Purpose : Self-checking bench for pipe_hazard_ctrl. A behavioural model
//           tracks the pipeline mode (running, draining with cycles left,
//           halted) and the stall count; a compare process checks every
//           cycle. Directed scenarios add hand-computed literal checks.
// Control vector bit order used throughout:
//   {pc_en, if_id_stall, if_id_flush, id_ex_stall_thru, id_ex_stall_kill,
//    id_ex_flush, ex_mem_stall}
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int DRAIN = 2;
    localparam int CW    = 4;   // narrow counter so saturation is reachable

    localparam logic [6:0] C_IDLE   = 7'b1000000;
    localparam logic [6:0] C_MWAIT  = 7'b0101001;
    localparam logic [6:0] C_REDIR  = 7'b1010010;
    localparam logic [6:0] C_HALT   = 7'b0010010;
    localparam logic [6:0] C_LDUSE  = 7'b0100100;
    localparam logic [6:0] C_HALTED = 7'b0100000;

    logic clk = 1'b0;
    logic rst;
    bit   chk_en = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz_if ();

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .hz    (hz_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {hz_if.o_pc_en, hz_if.o_if_id_stall, hz_if.o_if_id_flush,
                hz_if.o_id_ex_stall_thru, hz_if.o_id_ex_stall_kill,
                hz_if.o_id_ex_flush, hz_if.o_ex_mem_stall};
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int m_drain_left  = -1;   // -1: not draining
    bit m_halted      = 1'b0;
    int m_stalls      = 0;

    initial begin
        logic [6:0] exp_ctrl;
        bit mw, rd, hl, lu;
        int n_drain, n_stalls;
        bit n_halted;
        forever begin
            @(negedge clk);
            n_drain  = m_drain_left;
            n_halted = m_halted;
            n_stalls = m_stalls;
            if (chk_en) begin
                mw = hz_if.i_dmem_req && !hz_if.i_dmem_ready;
                rd = hz_if.i_ex_valid && hz_if.i_ex_redirect;
                hl = hz_if.i_ex_valid && hz_if.i_ex_halt;
                lu = hz_if.i_ex_valid && hz_if.i_ex_mem_read && (hz_if.i_ex_rd_addr != 0) &&
                     hz_if.i_id_valid &&
                     ((hz_if.i_id_rs1_used && hz_if.i_id_rs1_addr == hz_if.i_ex_rd_addr) ||
                      (hz_if.i_id_rs2_used && hz_if.i_id_rs2_addr == hz_if.i_ex_rd_addr));

                if (m_halted)               exp_ctrl = C_HALTED;
                else if (m_drain_left >= 0) exp_ctrl = C_HALT | {6'b0, mw};
                else if (mw)                exp_ctrl = C_MWAIT;
                else if (rd)                exp_ctrl = C_REDIR;
                else if (hl)                exp_ctrl = C_HALT;
                else if (lu)                exp_ctrl = C_LDUSE;
                else                        exp_ctrl = C_IDLE;

                check("ctrl", 32'(ctrl_vec()), 32'(exp_ctrl));
                check("halted", 32'(hz_if.o_halted), 32'(m_halted));
                check("stall_cnt", 32'(hz_if.o_stall_cnt), 32'(m_stalls));

                if (rst) begin
                    n_drain = -1; n_halted = 1'b0; n_stalls = 0;
                end else if (m_halted) begin
                    // frozen until reset
                end else if (m_drain_left >= 0) begin
                    if (!mw) begin
                        if (m_drain_left <= 1) begin
                            n_drain = -1; n_halted = 1'b1;
                        end else begin
                            n_drain = m_drain_left - 1;
                        end
                    end
                end else begin
                    if (!exp_ctrl[6] && m_stalls < (1 << CW) - 1) n_stalls = m_stalls + 1;
                    if (!mw && !rd && hl) n_drain = DRAIN;
                end
            end
            @(posedge clk);
            if (chk_en) begin
                m_drain_left = n_drain;
                m_halted     = n_halted;
                m_stalls     = n_stalls;
            end
        end
    end

    // ------------------------------- stimulus -------------------------------
    task automatic idle();
        hz_if.i_id_valid    = 1'b0;
        hz_if.i_id_rs1_addr = 5'd0;
        hz_if.i_id_rs2_addr = 5'd0;
        hz_if.i_id_rs1_used = 1'b0;
        hz_if.i_id_rs2_used = 1'b0;
        hz_if.i_ex_valid    = 1'b0;
        hz_if.i_ex_mem_read = 1'b0;
        hz_if.i_ex_rd_addr  = 5'd0;
        hz_if.i_ex_redirect = 1'b0;
        hz_if.i_ex_halt     = 1'b0;
        hz_if.i_dmem_req    = 1'b0;
        hz_if.i_dmem_ready  = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd_addr);
        hz_if.i_ex_valid    = 1'b1;
        hz_if.i_ex_mem_read = 1'b1;
        hz_if.i_ex_rd_addr  = rd_addr;
        hz_if.i_id_valid    = 1'b1;
        hz_if.i_id_rs1_addr = 5'd7;
        hz_if.i_id_rs1_used = 1'b1;
        hz_if.i_id_rs2_addr = 5'd5;
        hz_if.i_id_rs2_used = 1'b1;
    endtask

    task automatic set_mem_wait();
        hz_if.i_dmem_req   = 1'b1;
        hz_if.i_dmem_ready = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        next_cyc();
        next_cyc();
        chk_en = 1'b1;

        // Reset state, idle inputs.
        at_neg();
        check("rst_ctrl", 32'(ctrl_vec()), 32'(C_IDLE));
        check("rst_halted", 32'(hz_if.o_halted), 32'd0);
        check("rst_cnt", 32'(hz_if.o_stall_cnt), 32'd0);
        next_cyc();
        rst = 1'b0;

        // Load-use on rs2 = rd = 5: one bubble, then the load leaves EX.
        set_load_use(5'd5);
        at_neg();
        check("lu_ctrl", 32'(ctrl_vec()), 32'(C_LDUSE));
        next_cyc();
        hz_if.i_ex_valid = 1'b0;
        at_neg();
        check("lu_after_ctrl", 32'(ctrl_vec()), 32'(C_IDLE));
        check("lu_cnt", 32'(hz_if.o_stall_cnt), 32'd1);
        next_cyc();

        // Same pattern with rd = x0: no hazard.
        do_reset();
        set_load_use(5'd0);
        at_neg();
        check("x0_ctrl", 32'(ctrl_vec()), 32'(C_IDLE));
        next_cyc();
        idle();
        at_neg();
        check("x0_cnt", 32'(hz_if.o_stall_cnt), 32'd0);
        next_cyc();

        // Load-use with matching register but operand unused: no hazard.
        set_load_use(5'd5);
        hz_if.i_id_rs2_used = 1'b0;
        at_neg();
        check("unused_ctrl", 32'(ctrl_vec()), 32'(C_IDLE));
        next_cyc();

        // Mem wait beats redirect for three cycles, then redirect flushes.
        do_reset();
        hz_if.i_ex_valid    = 1'b1;
        hz_if.i_ex_redirect = 1'b1;
        set_mem_wait();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("mw_redir_ctrl", 32'(ctrl_vec()), 32'(C_MWAIT));
            next_cyc();
        end
        hz_if.i_dmem_ready = 1'b1;
        at_neg();
        check("redir_after_mw", 32'(ctrl_vec()), 32'(C_REDIR));
        check("mw_cnt", 32'(hz_if.o_stall_cnt), 32'd3);
        next_cyc();

        // Redirect beats load-use.
        idle();
        set_load_use(5'd5);
        hz_if.i_ex_redirect = 1'b1;
        at_neg();
        check("redir_lu_ctrl", 32'(ctrl_vec()), 32'(C_REDIR));
        next_cyc();

        // Halt held off by mem wait, then halt taken; mem wait during DRAIN.
        do_reset();
        hz_if.i_ex_valid = 1'b1;
        hz_if.i_ex_halt  = 1'b1;
        set_mem_wait();
        at_neg();
        check("mw_halt_ctrl", 32'(ctrl_vec()), 32'(C_MWAIT));
        next_cyc();
        hz_if.i_dmem_req = 1'b0;                       // T0: halt cycle
        at_neg();
        check("halt_t0", 32'(ctrl_vec()), 32'(C_HALT));
        next_cyc();
        idle();
        set_mem_wait();                                 // T1: DRAIN, mem wait
        at_neg();
        check("drain_mw", 32'(ctrl_vec()), 32'(C_HALT | 7'b0000001));
        next_cyc();
        idle();                                         // T2, T3: DRAIN
        for (int i = 0; i < 2; i++) begin
            at_neg();
            check("drain_halted", 32'(hz_if.o_halted), 32'd0);
            next_cyc();
        end
        hz_if.i_ex_valid    = 1'b1;                     // T4+: HALTED ignores inputs
        hz_if.i_ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("halted_flag", 32'(hz_if.o_halted), 32'd1);
            check("halted_ctrl", 32'(ctrl_vec()), 32'(C_HALTED));
            check("halted_cnt", 32'(hz_if.o_stall_cnt), 32'd2);
            next_cyc();
            if (i == 0) set_mem_wait();
        end

        // One-cycle reset from HALTED.
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        idle();
        at_neg();
        check("rst_halted_flag", 32'(hz_if.o_halted), 32'd0);
        check("rst_halted_cnt", 32'(hz_if.o_stall_cnt), 32'd0);
        check("rst_halted_pc", 32'(hz_if.o_pc_en), 32'd1);
        next_cyc();

        // Reset during DRAIN with mem wait pending.
        hz_if.i_ex_valid = 1'b1;
        hz_if.i_ex_halt  = 1'b1;
        next_cyc();
        idle();
        set_mem_wait();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        idle();
        at_neg();
        check("rst_drain_ctrl", 32'(ctrl_vec()), 32'(C_IDLE));
        next_cyc();

        // Stall counter saturates at all-ones.
        set_mem_wait();
        for (int i = 0; i < 18; i++) next_cyc();
        idle();
        at_neg();
        check("sat_cnt", 32'(hz_if.o_stall_cnt), 32'((1 << CW) - 1));
        next_cyc();

        // Mixed directed traffic, checked by the model only.
        for (int i = 0; i < 40; i++) begin
            idle();
            hz_if.i_ex_valid    = i[0];
            hz_if.i_ex_mem_read = i[1];
            hz_if.i_ex_rd_addr  = 5'(i % 4);
            hz_if.i_id_valid    = 1'b1;
            hz_if.i_id_rs1_addr = 5'(i % 3);
            hz_if.i_id_rs1_used = i[2];
            hz_if.i_ex_redirect = (i % 7 == 3);
            hz_if.i_dmem_req    = (i % 5 == 1);
            hz_if.i_dmem_ready  = (i % 10 == 1);
            next_cyc();
        end

        idle();
        next_cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
